// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures the period and high time of a PWM input in clk cycles.
// Parameters: CNT_BITS sets the counter and output width. TIMEOUT is the number
// of cycles without a rising edge before stuck is raised.
// Ports: clk and rst (asynchronous reset, active high). pwm_in is an asynchronous input.
// The outputs are meas_valid (a one-cycle strobe), period_out and high_out (the
// last measurement), stuck, and stuck_level (the input level when stuck was raised).
// The optional glitch filter is enabled by the macro PWM_METER_GLITCH_FILTER_EN.
`timescale 1ns/1ps

module pwm_duty_meter #(
  parameter int CNT_BITS = 16,
  parameter int TIMEOUT  = 60000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  output logic                meas_valid,
  output logic [CNT_BITS-1:0] period_out,
  output logic [CNT_BITS-1:0] high_out,
  output logic                stuck,
  output logic                stuck_level
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] TO_CNT  = CNT_BITS'(TIMEOUT);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t              state_q, state_d;
  logic                sync_q1, sync_q2;
  logic                lvl, lvl_d, rise;
  logic [CNT_BITS-1:0] per_cnt, hi_cnt;
  logic                capture, timeout, clear_stuck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pwm_in;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PWM_METER_GLITCH_FILTER_EN
  logic hist1, hist2, filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist1  <= 1'b0;
      hist2  <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      hist1  <= sync_q2;
      hist2  <= hist1;
      filt_q <= lvl;
    end
  end

  // Follow the input only once three samples in a row agree.
  always_comb begin
    lvl = filt_q;
    if (sync_q2 & hist1 & hist2)
      lvl = 1'b1;
    else if (~(sync_q2 | hist1 | hist2))
      lvl = 1'b0;
  end
`else
  assign lvl = sync_q2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_d <= 1'b0;
    else     lvl_d <= lvl;
  end

  assign rise = lvl & ~lvl_d;

  // On a rise, both counters restart at 1 so that the edge cycle is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_BITS'(1);
      hi_cnt  <= CNT_BITS'(1);
    end else begin
      if (per_cnt != CNT_MAX)
        per_cnt <= per_cnt + 1'b1;
      if (lvl && hi_cnt != CNT_MAX)
        hi_cnt <= hi_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = MEASURE;
      MEASURE: if (!rise && per_cnt == TO_CNT) state_d = IDLE;
    endcase
  end

  always_comb begin
    capture     = (state_q == MEASURE) & rise;
    timeout     = (state_q == MEASURE) & ~rise & (per_cnt == TO_CNT);
    clear_stuck = (state_q == IDLE) & rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_valid  <= 1'b0;
      period_out  <= '0;
      high_out    <= '0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= capture;
      if (capture) begin
        period_out <= per_cnt;
        high_out   <= hi_cnt;
      end
      if (timeout) begin
        stuck       <= 1'b1;
        stuck_level <= lvl;
      end else if (clear_stuck) begin
        stuck <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: table-driven and randomized bench for pwm_duty_meter
// with a waveform-level reference model.
`timescale 1ns/1ps

module tb_pwm_duty_meter;

  localparam int CW   = 16;
  localparam int TO_A = 3000;
  localparam int TO_B = 200;
`ifdef PWM_METER_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_a = 1'b0;
  logic pwm_b = 1'b0;
  logic mv_a, st_a, sl_a, mv_b, st_b, sl_b;
  logic [CW-1:0] per_a, hi_a, per_b, hi_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct { int p; int h; int c; } meas_t;
  typedef struct { int p; int h; int n; int exp_p; int exp_h; } vec_t;

  meas_t sbq[$];
  logic  armed = 1'b0;
  logic  ideal_prev = 1'b0;
  int    since = 0;
  int    hicnt = 0;

  pwm_duty_meter #(.CNT_BITS(CW), .TIMEOUT(TO_A)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_a),
    .meas_valid(mv_a), .period_out(per_a), .high_out(hi_a),
    .stuck(st_a), .stuck_level(sl_a)
  );

  pwm_duty_meter #(.CNT_BITS(CW), .TIMEOUT(TO_B)) dut_t (
    .clk(clk), .rst(rst), .pwm_in(pwm_b),
    .meas_valid(mv_b), .period_out(per_b), .high_out(hi_b),
    .stuck(st_b), .stuck_level(sl_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    armed = 1'b0;
    ideal_prev = 1'b0;
    since = 0;
    hicnt = 0;
    sbq.delete();
  endtask

  // Drives one cycle. v is the intended level that the model sees, and phys is the level actually driven.
  task automatic drive_a(input logic v, input logic phys);
    @(negedge clk);
    pwm_a = phys;
    if (v && !ideal_prev) begin
      if (armed) sbq.push_back('{since, hicnt, cyc + LAT});
      armed = 1'b1;
      since = 0;
      hicnt = 0;
    end
    since++;
    if (v) hicnt++;
    ideal_prev = v;
  endtask

  task automatic wave_a(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++)
        drive_a(i < h, i < h);
  endtask

  task automatic close_a();
    drive_a(1'b1, 1'b1);
    drive_a(1'b1, 1'b1);
    drive_a(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive_a(1'b0, 1'b0);
  endtask

  task automatic flush_check(input string name);
    repeat (LAT + 3) @(negedge clk);
    chk({name, "_missing_valid"}, sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pwm_a = 1'b0;
    pwm_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic monitor();
    meas_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (mv_a) begin
          chk("valid_back_to_back", prev, 0);
          chk("valid_has_pending_edge", sbq.size() > 0, 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("period_out", per_a, e.p);
            chk("high_out", hi_a, e.h);
            chk("valid_cycle", cyc, e.c);
          end
        end
        prev = mv_a;
      end
    end
  endtask

  initial begin
    vec_t tbl[$];
    int p, h, c0, c1, c2, first, seen;

    fork
      monitor();
    join_none

    @(negedge clk);
    chk("rst_mv", mv_a, 0);
    chk("rst_period", per_a, 0);
    chk("rst_high", hi_a, 0);
    chk("rst_stuck", st_a, 0);
    chk("rst_stuck_level", sl_b, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_mv", mv_a, 0);
    chk("idle_period", per_a, 0);
    chk("idle_stuck", st_b, 0);

    tbl.push_back('{1024, 307, 5, 1024, 307});
    tbl.push_back('{100, 50, 4, 100, 50});
    tbl.push_back('{37, 3, 3, 37, 3});
`ifndef PWM_METER_GLITCH_FILTER_EN
    tbl.push_back('{2, 1, 8, 2, 1});
    tbl.push_back('{5, 4, 4, 5, 4});
`endif
    for (int i = 0; i < 6; i++) begin
      p = int'($urandom_range(400, 6));
      h = int'($urandom_range(p - 3, 3));
      tbl.push_back('{p, h, 3, p, h});
    end

    foreach (tbl[i]) begin
      do_reset();
      for (int j = 0; j < 3; j++) drive_a(1'b0, 1'b0);
      wave_a(tbl[i].p, tbl[i].h, tbl[i].n);
      close_a();
      flush_check("tbl");
      chk("tbl_last_period", per_a, tbl[i].exp_p);
      chk("tbl_last_high", hi_a, tbl[i].exp_h);
    end

    // duty step 100 -> 900
    do_reset();
    for (int j = 0; j < 3; j++) drive_a(1'b0, 1'b0);
    wave_a(1024, 100, 3);
    wave_a(1024, 900, 3);
    close_a();
    flush_check("duty_step");
    chk("duty_step_high", hi_a, 900);

`ifdef PWM_METER_GLITCH_FILTER_EN
    do_reset();
    for (int j = 0; j < 3; j++) drive_a(1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 100; i++)
        drive_a(i < 50, (i < 50 && i != 20 && i != 21) || i == 75);
    close_a();
    flush_check("glitch");
    chk("glitch_period", per_a, 100);
    chk("glitch_high", hi_a, 50);
`endif

    // asynchronous reset in the middle of a period
    do_reset();
    for (int j = 0; j < 3; j++) drive_a(1'b0, 1'b0);
    wave_a(1024, 307, 2);
    for (int i = 0; i < 150; i++) drive_a(1'b1, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_period", per_a, 0);
    chk("async_rst_high", hi_a, 0);
    chk("async_rst_mv", mv_a, 0);
    chk("async_rst_stuck", st_a, 0);
    model_clear();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 100; i++) drive_a(1'b1, 1'b1);
    for (int i = 0; i < 500; i++) drive_a(1'b0, 1'b0);
    wave_a(1024, 307, 2);
    close_a();
    flush_check("post_rst");

    // stuck detection on the short-timeout instance
    do_reset();
    repeat (3) @(negedge clk);
    @(negedge clk);
    pwm_b = 1'b1;
    c0 = cyc;
    first = -1;
    seen = 0;
    for (int i = 0; i < 400 && first < 0; i++) begin
      @(negedge clk);
      if (mv_b) seen++;
      if (st_b) first = cyc;
    end
    chk("stuck_cycle", first - c0, LAT + TO_B);
    chk("stuck_level_high", sl_b, 1);
    repeat (5) begin
      @(negedge clk);
      if (mv_b) seen++;
      pwm_b = 1'b0;
    end
    @(negedge clk);
    pwm_b = 1'b1;
    c1 = cyc;
    for (int i = 1; i < 30; i++) begin
      @(negedge clk);
      pwm_b = (i < 10);
      if (mv_b) seen++;
      if (i == LAT - 1) chk("stuck_held_to_edge", st_b, 1);
      if (i == LAT) chk("stuck_cleared", st_b, 0);
    end
    chk("stuck_rearm_no_valid", seen, 0);
    @(negedge clk);
    pwm_b = 1'b1;
    c2 = cyc;
    first = -1;
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      pwm_b = (i < 5);
      if (mv_b && first < 0) first = cyc;
      if (mv_b && first < 0) first = cyc;
    end
    chk("rearm_valid_cycle", first - c2, LAT);
    chk("rearm_period", per_b, 30);
    chk("rearm_high", hi_b, 10);
    first = -1;
    for (int i = 0; i < 400 && first < 0; i++) begin
      @(negedge clk);
      if (st_b) first = cyc;
    end
    chk("stuck_low_cycle", first - c2, LAT + TO_B);
    chk("stuck_level_low", sl_b, 0);
    chk("stuck_holds_period", per_b, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_meter.md
# pwm_duty_meter

Measures period and high-time of a PWM waveform, such as the output of the ramp PWM generator, in system-clock cycles. It sits directly downstream of the PWM stage as a self-check and telemetry block. It synchronises the input, detects rising edges, counts cycles per PWM period, and publishes one measurement per period with a single-cycle valid strobe. A timeout flags a stuck input.

## Interface
- CNT_BITS, 16, width of period/high counters and outputs
- TIMEOUT, 60000, cycles without a rising edge before declaring stuck; must be ≤ 2^CNT_BITS−1
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- pwm_in  input  1  asynchronous PWM waveform to measure
- meas_valid  output  1  one-cycle pulse: period_out/high_out updated
- period_out  output  CNT_BITS  cycles between last two rising edges
- high_out  output  CNT_BITS  cycles pwm was high within that period
- stuck  output  1  no rising edge for TIMEOUT cycles
- stuck_level  output  1  filtered input level when stuck asserted

## Operation
- Input path: 2-flop synchroniser → optional filter (see Configuration) → `lvl`. A registered `lvl_d` gives `rise = lvl & ~lvl_d`.
- Counters: `per_cnt` increments every cycle. `hi_cnt` increments each cycle `lvl`=1. Both saturate at 2^CNT_BITS−1 and never wrap.
- FSM, two states:
  - IDLE (reset state): on `rise` → MEASURE, per_cnt←1, hi_cnt←1; no meas_valid.
  - MEASURE, on `rise`: period_out←per_cnt, high_out←hi_cnt, meas_valid=1, per_cnt←1, hi_cnt←1.
  - MEASURE, when per_cnt reaches TIMEOUT without `rise`: stuck←1, stuck_level←lvl, → IDLE; period_out/high_out hold.
  - IDLE with stuck=1: per_cnt is not used; first `rise` clears stuck and arms.
- Result semantics: a waveform high for H cycles of a P-cycle period yields period_out=P, high_out=H, with 1 ≤ H < P.
- Minimum measurable period is 2 cycles without filter and 6 cycles with filter. Shorter pulses are undefined without filter and suppressed with filter.
- `rise` and timeout in the same cycle: rise wins; no stuck.
- meas_valid is never asserted on consecutive cycles.

## Timing
- Reset values: meas_valid=0, period_out=0, high_out=0, stuck=0, stuck_level=0, FSM=IDLE, counters=0, synchroniser=0.
- Reset mid-measurement discards the partial period. The first edge after reset release only arms.
- Latency without filter: pwm_in sampled high at clk edge k → meas_valid high in the cycle after edge k+2.
- Latency with filter: the same pulse appears after edge k+4.
- Outputs are registered; period_out/high_out are stable from the meas_valid cycle until the next meas_valid.
- stuck asserts exactly TIMEOUT cycles after the per_cnt restart of the last accepted edge.

## Configuration
- Macro `PWM_METER_GLITCH_FILTER_EN`.
- Defined: `lvl` changes only after 3 consecutive synchronised samples differ from the current `lvl`. Pulses or gaps ≤2 cycles are ignored. Adds 2 cycles of latency.
- Undefined: `lvl` = synchroniser output directly, with no filter logic.
- Measured P and H are unchanged by the filter for clean inputs with both phases ≥3 cycles.

## Test plan
- Period 1024, high 307, 5 periods → first edge silent; then meas_valid every 1024 cycles with period_out=1024, high_out=307.
- Duty step 100→900 of period 1024 → the first period fully at the new duty reports high_out=900. No measurement reports a value other than 100 or 900, except the single transition period, which reports the actual cycles high.
- pwm_in held high after an edge, TIMEOUT=200 → stuck=1 and stuck_level=1 exactly 200 cycles after the edge. Next rising edge clears stuck with no meas_valid; the following edge yields a valid measurement.
- rst pulsed mid-period (asynchronous, between clk edges) → all outputs 0 immediately; first post-reset edge gives no meas_valid.
- Filter on: 1- and 2-cycle glitches injected into 50/100 waveform → reports stay period_out=100, high_out=50; meas_valid latency is 2 cycles longer than filter-off.
- Period 2, high 1, filter off → period_out=2, high_out=1 every 2 cycles.
